// File: rtl/cacode_arb_phi_omega_pkg.sv
// -----------------------------------------------------------------------------
// cacode_arb_phi_omega_pkg
// Shared constants and helpers for the GPS C/A code generator slice:
//   - G1/G2 feedback tap masks (bit i = LFSR stage i+1)
//   - LFSR initial value, LFSR length, code length, NCO accumulator width
//   - single-step LFSR function, tap selection, and GF(2) matrix helpers used
//     to jump an LFSR forward by an arbitrary number of steps in one cycle
// -----------------------------------------------------------------------------
package cacode_arb_phi_omega_pkg;

    localparam int LFSR_LEN = 10;
    localparam int CODE_LEN = 1023;
    localparam int NCO_W    = 8;

    typedef logic [LFSR_LEN-1:0] lfsr_t;
    // Column j holds the image of basis vector e_j under the linear map.
    typedef lfsr_t [LFSR_LEN-1:0] gf2_mat_t;

    // G1: stages 3 and 10.  G2: stages 2, 3, 6, 8, 9, 10.
    localparam lfsr_t G1_TAPS   = 10'h204;
    localparam lfsr_t G2_TAPS   = 10'h3A6;
    localparam lfsr_t LFSR_INIT = 10'h3FF;

    // Fibonacci step: XOR of tapped stages enters stage 1, everything moves up.
    function automatic lfsr_t lfsr_step(input lfsr_t s, input lfsr_t taps);
        return {s[LFSR_LEN-2:0], ^(s & taps)};
    endfunction

    // Stage select 1..10; any other value contributes 0.
    function automatic logic tap_bit(input lfsr_t s, input logic [3:0] t);
        logic r;
        r = 1'b0;
        for (int i = 0; i < LFSR_LEN; i++) begin
            if (t == 4'(i + 1)) r = s[i];
        end
        return r;
    endfunction

    function automatic lfsr_t mat_apply(input gf2_mat_t m, input lfsr_t v);
        lfsr_t r;
        r = '0;
        for (int j = 0; j < LFSR_LEN; j++) begin
            if (v[j]) r = r ^ m[j];
        end
        return r;
    endfunction

    function automatic gf2_mat_t mat_mul(input gf2_mat_t a, input gf2_mat_t b);
        gf2_mat_t r;
        for (int j = 0; j < LFSR_LEN; j++) r[j] = mat_apply(a, b[j]);
        return r;
    endfunction

    function automatic gf2_mat_t step_mat(input lfsr_t taps);
        gf2_mat_t m;
        for (int j = 0; j < LFSR_LEN; j++) m[j] = lfsr_step(lfsr_t'(1) << j, taps);
        return m;
    endfunction

    // Advance s by n steps: apply A^(2^k) for every set bit k of n.  The
    // matrices depend only on constants, so synthesis folds them into a fixed
    // XOR network selected by n.
    function automatic lfsr_t lfsr_jump(input lfsr_t s, input logic [9:0] n, input lfsr_t taps);
        gf2_mat_t m;
        lfsr_t    r;
        m = step_mat(taps);
        r = s;
        for (int k = 0; k < 10; k++) begin
            if (n[k]) r = mat_apply(m, r);
            m = mat_mul(m, m);
        end
        return r;
    endfunction

endpackage

// File: rtl/code_phase_to_lfsr.sv
// -----------------------------------------------------------------------------
// code_phase_to_lfsr
// Converts a code phase (chips from epoch) into the G1/G2 register states that
// the generator reaches from all-ones after (phase mod 1023) steps.  The result
// is registered one clock after phase changes and is meant to drive the g1/g2
// load inputs of cacode_arb_phi_omega.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-low reset (outputs return to all-ones)
//   phase  in   [9:0] code phase; 1023 is treated as 0
//   g1     out  [9:0] G1 state for that phase
//   g2     out  [9:0] G2 state for that phase
// -----------------------------------------------------------------------------
module code_phase_to_lfsr
    import cacode_arb_phi_omega_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] phase,
    output logic [9:0] g1,
    output logic [9:0] g2
);

    logic [9:0] steps;

    // Both LFSRs have period 1023, so phase 1023 lands on the epoch state.
    assign steps = (phase == 10'(CODE_LEN)) ? 10'd0 : phase;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the reset branch is asynchronous via the sensitivity list.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g1 <= LFSR_INIT;
            g2 <= LFSR_INIT;
        end else begin
            g1 <= lfsr_jump(LFSR_INIT, steps, G1_TAPS);
            g2 <= lfsr_jump(LFSR_INIT, steps, G2_TAPS);
        end
    end

endmodule

// File: rtl/cacode_arb_phi_omega.sv
// -----------------------------------------------------------------------------
// cacode_arb_phi_omega
// GPS C/A code generator with arbitrary G2 tap selection and an NCO-driven
// chip rate.  An 8-bit phase accumulator adds nco_omega every clock; each
// carry out advances G1 and G2 by one step, giving chip rate f_clk*omega/256.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset (G1 = G2 = all-ones, acc = 0)
//   g1, g2     in   [9:0] load states (bit i = stage i+1)
//   set_reg    in   synchronous load strobe; clears acc, beats any NCO carry
//   T0, T1     in   [3:0] G2 tap stage numbers 1..10 (others contribute 0)
//   nco_omega  in   [7:0] NCO increment per clock
//   chip       out  G1 stage 10 ^ G2[T0] ^ G2[T1], combinational from state
// -----------------------------------------------------------------------------
module cacode_arb_phi_omega
    import cacode_arb_phi_omega_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] g1,
    input  logic [9:0] g2,
    input  logic       set_reg,
    input  logic [3:0] T0,
    input  logic [3:0] T1,
    input  logic [7:0] nco_omega,
    output logic       chip
);

    lfsr_t            g1_state;
    lfsr_t            g2_state;
    logic [NCO_W-1:0] acc;
    logic [NCO_W:0]   acc_sum;

    // Bit NCO_W of the widened sum is the carry that paces the chips.
    assign acc_sum = {1'b0, acc} + {1'b0, nco_omega};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g1_state <= LFSR_INIT;
            g2_state <= LFSR_INIT;
            acc      <= '0;
        end else if (set_reg) begin
            g1_state <= g1;
            g2_state <= g2;
            acc      <= '0;
        end else begin
            acc <= acc_sum[NCO_W-1:0];
            if (acc_sum[NCO_W]) begin
                g1_state <= lfsr_step(g1_state, G1_TAPS);
                g2_state <= lfsr_step(g2_state, G2_TAPS);
            end
        end
    end

    // Equal taps select the same bit twice and cancel through the XOR.
    assign chip = g1_state[LFSR_LEN-1] ^ tap_bit(g2_state, T0) ^ tap_bit(g2_state, T1);

endmodule

// File: tb/tb_cacode_arb_phi_omega.sv
// -----------------------------------------------------------------------------
// tb_cacode_arb_phi_omega
// Directed and randomized bench for cacode_arb_phi_omega and its companion
// code_phase_to_lfsr.  The reference model keeps G1/G2 as arrays of stage bits
// (stage 1..10) and derives the number of chip steps from the running sum of
// NCO increments (steps = floor(sum/256)).
// -----------------------------------------------------------------------------
module tb_cacode_arb_phi_omega;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] tb_g1, tb_g2;
    logic       use_cpl;
    logic       set_reg;
    logic [3:0] T0, T1;
    logic [7:0] nco_omega;
    logic       chip;
    logic [9:0] phase;
    logic [9:0] cpl_g1, cpl_g2;
    logic [9:0] dut_g1, dut_g2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: stage k of each register is m1[k] / m2[k].
    bit m1 [1:10];
    bit m2 [1:10];
    int nco_total;
    int nco_steps;

    logic [0:9] prn1 = 10'b1100100000;

    always #5 clk = ~clk;

    assign dut_g1 = use_cpl ? cpl_g1 : tb_g1;
    assign dut_g2 = use_cpl ? cpl_g2 : tb_g2;

    cacode_arb_phi_omega dut (
        .clk       (clk),
        .rst       (rst),
        .g1        (dut_g1),
        .g2        (dut_g2),
        .set_reg   (set_reg),
        .T0        (T0),
        .T1        (T1),
        .nco_omega (nco_omega),
        .chip      (chip)
    );

    code_phase_to_lfsr cpl (
        .clk   (clk),
        .rst   (rst),
        .phase (phase),
        .g1    (cpl_g1),
        .g2    (cpl_g2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_load(input logic [9:0] a, input logic [9:0] b);
        for (int i = 1; i <= 10; i++) begin
            m1[i] = a[i-1];
            m2[i] = b[i-1];
        end
        nco_total = 0;
        nco_steps = 0;
    endtask

    task automatic model_step();
        bit f1, f2;
        f1 = m1[3] ^ m1[10];
        f2 = m2[2] ^ m2[3] ^ m2[6] ^ m2[8] ^ m2[9] ^ m2[10];
        for (int i = 10; i >= 2; i--) begin
            m1[i] = m1[i-1];
            m2[i] = m2[i-1];
        end
        m1[1] = f1;
        m2[1] = f2;
    endtask

    function automatic bit model_tap(input int t);
        return (t >= 1 && t <= 10) ? m2[t] : 1'b0;
    endfunction

    function automatic bit model_chip();
        return m1[10] ^ model_tap(int'(T0)) ^ model_tap(int'(T1));
    endfunction

    function automatic logic [9:0] pack1();
        logic [9:0] r;
        for (int i = 1; i <= 10; i++) r[i-1] = m1[i];
        return r;
    endfunction

    function automatic logic [9:0] pack2();
        logic [9:0] r;
        for (int i = 1; i <= 10; i++) r[i-1] = m2[i];
        return r;
    endfunction

    // States reached from all-ones after (p mod 1023) steps; main model preserved.
    task automatic phase_model(input int p, output logic [9:0] e1, output logic [9:0] e2);
        bit s1 [1:10];
        bit s2 [1:10];
        int st, tt;
        s1 = m1; s2 = m2; st = nco_steps; tt = nco_total;
        model_load(10'h3FF, 10'h3FF);
        for (int i = 0; i < p % 1023; i++) model_step();
        e1 = pack1();
        e2 = pack2();
        m1 = s1; m2 = s2; nco_steps = st; nco_total = tt;
    endtask

    // One rising edge; inputs are captured before it, the model follows it.
    task automatic tick();
        logic       s;
        int         w;
        logic [9:0] a, b;
        s = set_reg;
        w = int'(nco_omega);
        a = tb_g1;
        b = tb_g2;
        @(posedge clk);
        #1;
        if (s) begin
            model_load(a, b);
        end else begin
            nco_total += w;
            while (nco_total / 256 > nco_steps) begin
                model_step();
                nco_steps++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] e1, e2;
        logic [9:0] prev;
        int         cnt;
        int         ones;
        bit         held;

        // ---------------- reset state ----------------
        rst = 1'b0; use_cpl = 1'b0; set_reg = 1'b0;
        tb_g1 = '0; tb_g2 = '0; T0 = 4'd2; T1 = 4'd6; nco_omega = 8'd128; phase = '0;
        model_load(10'h3FF, 10'h3FF);
        #12;
        check("reset_g1", 32'(dut.g1_state), 32'h3FF);
        check("reset_g2", 32'(dut.g2_state), 32'h3FF);
        check("reset_acc", 32'(dut.acc), 32'h0);
        check("reset_chip", 32'(chip), 32'h1);
        check("reset_cpl_g1", 32'(cpl_g1), 32'h3FF);
        check("reset_cpl_g2", 32'(cpl_g2), 32'h3FF);

        // ---------------- PRN1 first 10 chips, each held 2 clocks ----------------
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("prn1_k0", 32'(chip), 32'(prn1[0]));
        for (int k = 1; k < 20; k++) begin
            tick();
            check("prn1_seq", 32'(chip), 32'(prn1[k/2]));
            check("prn1_model", 32'(chip), 32'(model_chip()));
        end

        // ---------------- companion phase conversion ----------------
        phase = 10'd1;
        tick();
        check("cpl_ph1_g1", 32'(cpl_g1), 32'h3FE);
        check("cpl_ph1_g2", 32'(cpl_g2), 32'h3FE);
        phase = 10'd0;
        tick();
        check("cpl_ph0_g1", 32'(cpl_g1), 32'h3FF);
        check("cpl_ph0_g2", 32'(cpl_g2), 32'h3FF);
        for (int i = 0; i < 6; i++) begin
            int p;
            p = (i == 0) ? 1023 : (i == 1) ? 1022 : int'($urandom_range(2, 1021));
            phase = 10'(p);
            phase_model(p, e1, e2);
            tick();
            check("cpl_rand_g1", 32'(cpl_g1), 32'(e1));
            check("cpl_rand_g2", 32'(cpl_g2), 32'(e2));
        end

        // ---------------- phase 1 load restarts at PRN1 chip index 1 ----------------
        phase = 10'd1;
        tick();
        phase_model(1, e1, e2);
        use_cpl = 1'b1; tb_g1 = e1; tb_g2 = e2; set_reg = 1'b1;
        tick();
        set_reg = 1'b0;
        check("load_acc", 32'(dut.acc), 32'h0);
        check("load_k0", 32'(chip), 32'(prn1[1]));
        for (int k = 1; k < 8; k++) begin
            tick();
            check("load_seq", 32'(chip), 32'(prn1[1 + k/2]));
        end
        use_cpl = 1'b0;

        // ---------------- omega = 0 holds the chip ----------------
        nco_omega = 8'd0;
        held = model_chip();
        for (int k = 0; k < 100; k++) begin
            tick();
            check("omega0_hold", 32'(chip), 32'(held));
        end

        // ---------------- omega = 255: 255 advances in 256 clocks ----------------
        tb_g1 = 10'h3FF; tb_g2 = 10'h3FF; set_reg = 1'b1;
        tick();
        set_reg = 1'b0; nco_omega = 8'd255;
        cnt = 0;
        prev = dut.g1_state;
        for (int k = 0; k < 256; k++) begin
            tick();
            if (dut.g1_state !== prev) cnt++;
            prev = dut.g1_state;
            check("omega255_chip", 32'(chip), 32'(model_chip()));
        end
        check("omega255_steps", 32'(cnt), 32'd255);

        // ---------------- full period at omega = 128 ----------------
        T0 = 4'd2; T1 = 4'd6; nco_omega = 8'd128;
        tb_g1 = 10'h3FF; tb_g2 = 10'h3FF; set_reg = 1'b1;
        tick();
        set_reg = 1'b0;
        ones = 0;
        for (int k = 0; k < 2046; k++) begin
            if (k % 2 == 0 && chip === 1'b1) ones++;
            tick();
            check("period_chip", 32'(chip), 32'(model_chip()));
        end
        check("period_ones", 32'(ones), 32'd512);
        check("period_g1", 32'(dut.g1_state), 32'h3FF);
        check("period_g2", 32'(dut.g2_state), 32'h3FF);

        // ---------------- load coincident with a carry ----------------
        tb_g1 = 10'h3FF; tb_g2 = 10'h3FF; set_reg = 1'b1;
        tick();
        set_reg = 1'b0;
        tick();
        tb_g1 = 10'h155; tb_g2 = 10'h2AA; set_reg = 1'b1;
        tick();
        set_reg = 1'b0;
        check("coinc_g1", 32'(dut.g1_state), 32'h155);
        check("coinc_g2", 32'(dut.g2_state), 32'h2AA);
        check("coinc_acc", 32'(dut.acc), 32'h0);

        // ---------------- all-zero load locks at zero ----------------
        tb_g1 = 10'h000; tb_g2 = 10'h000; set_reg = 1'b1;
        tick();
        set_reg = 1'b0; nco_omega = 8'd255;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("zero_chip", 32'(chip), 32'h0);
        end
        check("zero_g1", 32'(dut.g1_state), 32'h0);

        // ---------------- randomized taps, omega and loads ----------------
        for (int k = 0; k < 400; k++) begin
            nco_omega = 8'($urandom_range(0, 255));
            T0 = 4'($urandom_range(0, 15));
            T1 = ($urandom_range(0, 7) == 0) ? T0 : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) begin
                set_reg = 1'b1;
                tb_g1 = ($urandom_range(0, 3) == 0) ? 10'h0 : 10'($urandom);
                tb_g2 = 10'($urandom);
            end else begin
                set_reg = 1'b0;
            end
            tick();
            check("rand_chip", 32'(chip), 32'(model_chip()));
        end
        set_reg = 1'b0;

        // ---------------- asynchronous reset mid-run ----------------
        tb_g1 = 10'h3FF; tb_g2 = 10'h3FF; set_reg = 1'b1;
        tick();
        set_reg = 1'b0; nco_omega = 8'd77; T0 = 4'd2; T1 = 4'd6;
        for (int k = 0; k < 9; k++) tick();
        #2;
        rst = 1'b0;
        #1;
        check("async_g1", 32'(dut.g1_state), 32'h3FF);
        check("async_g2", 32'(dut.g2_state), 32'h3FF);
        check("async_acc", 32'(dut.acc), 32'h0);
        check("async_chip", 32'(chip), 32'h1);
        @(posedge clk);
        #1;
        check("async_hold_g1", 32'(dut.g1_state), 32'h3FF);
        check("async_hold_cpl", 32'(cpl_g1), 32'h3FF);
        nco_omega = 8'd128;
        model_load(10'h3FF, 10'h3FF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("resume_k0", 32'(chip), 32'(prn1[0]));
        for (int k = 1; k < 10; k++) begin
            tick();
            check("resume_seq", 32'(chip), 32'(prn1[k/2]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
